// File: rtl/vga_pkg.sv
// Shared constants, types and FSM encoding for the VGA framebuffer arbiter.
package vga_pkg;
  localparam int HRES           = 800;
  localparam int VRES           = 450;
  localparam int PIX_W          = 4;
  localparam int DATA_W         = 16;
  localparam int ADDR_W         = 17;
  localparam int PIX_PER_WORD   = DATA_W / PIX_W;
  localparam int WORDS_PER_LINE = HRES / PIX_PER_WORD;
  localparam int FB_WORDS       = WORDS_PER_LINE * VRES;

  typedef logic [PIX_W-1:0]  pixel_t;
  typedef logic [DATA_W-1:0] word_t;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } arb_state_t;
endpackage

// File: rtl/vga_pix_unpack.sv
// Captures the fetched RAM word, picks the pixel lane by the delayed x[1:0]
// and carries visible/hs/vs through the matching two-stage delay line.
module vga_pix_unpack #(
  parameter int PIX_W  = 4,
  parameter int DATA_W = 16
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  visible_i,
  input  logic [$clog2(DATA_W/PIX_W)-1:0]       sel_i,
  input  logic                                  hs_i,
  input  logic                                  vs_i,
  input  logic [DATA_W-1:0]                     rdata_i,
  output logic                                  hs_o,
  output logic                                  vs_o,
  output logic [PIX_W-1:0]                      pixel_o
);
  localparam int PPW   = DATA_W / PIX_W;
  localparam int SEL_W = $clog2(PPW);

  logic              vis_q;
  logic [SEL_W-1:0]  sel_q;
  logic              hs1_q, vs1_q;
  logic              hs2_q, vs2_q;
  logic [DATA_W-1:0] word_q;
  logic [PIX_W-1:0]  pixel_q;

  logic              load_word;
  logic [DATA_W-1:0] src_word;
  logic [PIX_W-1:0]  lane [PPW];
  logic [PIX_W-1:0]  pixel_d;

  // Lane 0 is consumed in the very cycle the RAM data arrives, so it bypasses word_q.
  always_comb begin
    load_word = vis_q && (sel_q == '0);
    src_word  = load_word ? rdata_i : word_q;
    pixel_d   = vis_q ? lane[sel_q] : '0;
  end

  for (genvar gi = 0; gi < PPW; gi++) begin : g_lane
    assign lane[gi] = src_word[gi*PIX_W +: PIX_W];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vis_q   <= 1'b0;
      sel_q   <= '0;
      hs1_q   <= 1'b1;
      vs1_q   <= 1'b1;
      hs2_q   <= 1'b1;
      vs2_q   <= 1'b1;
      word_q  <= '0;
      pixel_q <= '0;
    end else begin
      vis_q   <= visible_i;
      sel_q   <= sel_i;
      hs1_q   <= hs_i;
      vs1_q   <= vs_i;
      hs2_q   <= hs1_q;
      vs2_q   <= vs1_q;
      pixel_q <= pixel_d;
      if (load_word) begin
        word_q <= rdata_i;
      end
    end
  end

  assign hs_o    = hs2_q;
  assign vs_o    = vs2_q;
  assign pixel_o = pixel_q;
endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port video RAM arbiter: scan-out reads win every display slot, the
// clear engine and then the pixel writer share the remaining cycles.
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int HRES   = vga_pkg::HRES,
  parameter int VRES   = vga_pkg::VRES,
  parameter int PIX_W  = vga_pkg::PIX_W,
  parameter int DATA_W = vga_pkg::DATA_W,
  parameter int ADDR_W = vga_pkg::ADDR_W
) (
  input  logic              clk_vga,
  input  logic              rst_n,
  input  logic [9:0]        hc_visible,
  input  logic [9:0]        vc_visible,
  input  logic              hs_in,
  input  logic              vs_in,
  output logic              hs_out,
  output logic              vs_out,
  output logic [PIX_W-1:0]  pixel,
  input  logic              clear_start,
  input  logic [PIX_W-1:0]  clear_color,
  output logic              clear_busy,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int PPW   = DATA_W / PIX_W;
  localparam int SEL_W = $clog2(PPW);
  localparam int WPL   = HRES / PPW;
  localparam int FBW   = WPL * VRES;

  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] fill_q, fill_d;

  logic              visible;
  logic [9:0]        x_pos, y_pos;
  logic              disp_slot;
  logic [ADDR_W-1:0] disp_addr;
  logic              clr_grant;
  logic              wr_grant;
  logic              clr_last;

  assign visible   = (hc_visible != 10'd0) && (vc_visible != 10'd0);
  assign x_pos     = hc_visible - 10'd1;
  assign y_pos     = vc_visible - 10'd1;
  assign disp_slot = visible && (x_pos[SEL_W-1:0] == '0);
  assign disp_addr = ADDR_W'(y_pos) * ADDR_W'(WPL) + ADDR_W'(x_pos >> SEL_W);

  assign clr_grant = !disp_slot && (state_q == CLEAR);
  assign wr_grant  = !disp_slot && (state_q == IDLE) && wr_req;
  assign clr_last  = (cnt_q == ADDR_W'(FBW - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    case (state_q)
      IDLE: begin
        if (clear_start) begin
          state_d = CLEAR;
          cnt_d   = '0;
          fill_d  = {PPW{clear_color}};
        end
      end
      CLEAR: begin
        if (clr_grant) begin
          cnt_d = cnt_q + 1'b1;
          if (clr_last) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_vga or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
    end
  end

  // RAM port is combinational from the inputs; held quiet while reset is asserted.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    wr_ack    = 1'b0;
    if (rst_n) begin
      if (disp_slot) begin
        mem_en   = 1'b1;
        mem_addr = disp_addr;
      end else if (clr_grant) begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = cnt_q;
        mem_wdata = fill_q;
      end else if (wr_grant) begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = wr_addr;
        mem_wdata = wr_data;
        wr_ack    = 1'b1;
      end
    end
  end

  assign clear_busy = (state_q == CLEAR);

  vga_pix_unpack #(
    .PIX_W  (PIX_W),
    .DATA_W (DATA_W)
  ) u_unpack (
    .clk_i     (clk_vga),
    .rst_ni    (rst_n),
    .visible_i (visible),
    .sel_i     (x_pos[SEL_W-1:0]),
    .hs_i      (hs_in),
    .vs_i      (vs_in),
    .rdata_i   (mem_rdata),
    .hs_o      (hs_out),
    .vs_o      (vs_out),
    .pixel_o   (pixel)
  );
endmodule
